main_memory_arbiter: RTL and testbench

// - Shares the single MAIN_MEMORY port between INSTRUCTION_CACHE (read-only) and DATA_CACHE (read/write).
// - Replaces the direct dual-signal hookup into main memory: one requester owns the port per transaction.
// - Routes mem_status back to the owner only; the non-owner sees BUSY.
// - Read data (mem_data) is NOT routed through this block; it fans out to both caches directly.

---
 rtl/main_memory_arbiter.sv | 152 +++++++++++++++
 tb/tb_main_memory_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_arbiter.sv
// Arbiter sharing the single main-memory port between the read-only instruction
// cache and the read/write data cache, one owner per transaction.
module main_memory_arbiter #(
    parameter int ADDR_WIDTH       = 17,
    parameter int DATA_LEN         = 32,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int TIMEOUT          = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  i_cache_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       i_cache_mem_vis_addr,
    output logic [1:0]                  i_cache_mem_status,
    input  logic [1:0]                  d_cache_mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0]       d_cache_mem_vis_addr,
    input  logic [DATA_LEN-1:0]         d_cache_written_data,
    input  logic [2:0]                  d_cache_data_type,
    input  logic [ENTRY_INDEX_SIZE:0]   d_cache_write_length,
    output logic [1:0]                  d_cache_mem_status,
    output logic [1:0]                  mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]       mem_vis_addr,
    output logic [DATA_LEN-1:0]         mem_written_data,
    output logic [2:0]                  mem_data_type,
    output logic [ENTRY_INDEX_SIZE:0]   mem_write_length,
    input  logic [1:0]                  mem_status,
    output logic                        arb_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [1:0] SIG_IDLE  = 2'b00;
    localparam logic [1:0] SIG_READ  = 2'b01;
    localparam logic [1:0] SIG_WRITE = 2'b10;

    localparam logic [1:0] STAT_IDLE = 2'b00;
    localparam logic [1:0] STAT_BUSY = 2'b01;
    localparam logic [1:0] STAT_DONE = 2'b10;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_grant;
    logic       last_grant_next;
    logic [7:0] grant_cnt;
    logic [7:0] grant_cnt_next;
    logic       timeout_q;

    logic i_valid;
    logic d_valid;
    logic grant_active;
    logic owner_valid;

    assign i_valid      = (i_cache_mem_vis_signal == SIG_READ);
    assign d_valid      = (d_cache_mem_vis_signal == SIG_READ) ||
                          (d_cache_mem_vis_signal == SIG_WRITE);
    assign grant_active = (state == ST_GRANT_I) || (state == ST_GRANT_D);
    assign owner_valid  = (state == ST_GRANT_I) ? i_valid : d_valid;

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (i_valid && d_valid) begin
                    state_next = (last_grant == SIDE_D) ? ST_GRANT_I : ST_GRANT_D;
                end else if (i_valid) begin
                    state_next = ST_GRANT_I;
                end else if (d_valid) begin
                    state_next = ST_GRANT_D;
                end
            end
            ST_GRANT_I, ST_GRANT_D: begin
                if (mem_status == STAT_DONE) begin
                    state_next      = ST_RELEASE;
                    last_grant_next = (state == ST_GRANT_D) ? SIDE_D : SIDE_I;
                end else if (!owner_valid) begin
                    // Abandoned transaction does not count as a served turn.
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Held at zero outside a grant, so it always starts from zero on entry.
    always_comb begin
        grant_cnt_next = '0;
        if (grant_active) begin
            grant_cnt_next = (grant_cnt == TIMEOUT_CNT) ? grant_cnt : grant_cnt + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= SIDE_I;
            grant_cnt  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            grant_cnt  <= grant_cnt_next;
            if (grant_active && (grant_cnt_next == TIMEOUT_CNT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_vis_signal     = SIG_IDLE;
        mem_vis_addr       = '0;
        mem_written_data   = '0;
        mem_data_type      = '0;
        mem_write_length   = '0;
        i_cache_mem_status = i_valid ? STAT_BUSY : STAT_IDLE;
        d_cache_mem_status = d_valid ? STAT_BUSY : STAT_IDLE;
        if (!rst) begin
            // Reset silences the caches at once, not at the next edge.
            i_cache_mem_status = STAT_IDLE;
            d_cache_mem_status = STAT_IDLE;
        end else begin
            case (state)
                ST_GRANT_I: begin
                    mem_vis_signal     = i_valid ? SIG_READ : SIG_IDLE;
                    mem_vis_addr       = i_cache_mem_vis_addr;
                    i_cache_mem_status = mem_status;
                end
                ST_GRANT_D: begin
                    mem_vis_signal     = d_valid ? d_cache_mem_vis_signal : SIG_IDLE;
                    mem_vis_addr       = d_cache_mem_vis_addr;
                    mem_written_data   = d_cache_written_data;
                    mem_data_type      = d_cache_data_type;
                    mem_write_length   = d_cache_write_length;
                    d_cache_mem_status = mem_status;
                end
                default: ;
            endcase
        end
    end

    assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_main_memory_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int LW = 4;

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_BUSY = 2'b01;
    localparam logic [1:0] M_DONE = 2'b10;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [AW-1:0] T_IADDR = 17'h00010;
    localparam logic [AW-1:0] T_DADDR = 17'h00100;
    localparam logic [DW-1:0] T_DDATA = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    i_sig = '0;
    logic [AW-1:0] i_addr = '0;
    logic [1:0]    i_st;
    logic [1:0]    d_sig = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_data = '0;
    logic [2:0]    d_type = '0;
    logic [LW-1:0] d_len = '0;
    logic [1:0]    d_st;
    logic [1:0]    m_sig;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [2:0]    m_type;
    logic [LW-1:0] m_len;
    logic [1:0]    m_status = '0;
    logic          tmo;

    main_memory_arbiter dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_cache_mem_vis_signal (i_sig),
        .i_cache_mem_vis_addr   (i_addr),
        .i_cache_mem_status     (i_st),
        .d_cache_mem_vis_signal (d_sig),
        .d_cache_mem_vis_addr   (d_addr),
        .d_cache_written_data   (d_data),
        .d_cache_data_type      (d_type),
        .d_cache_write_length   (d_len),
        .d_cache_mem_status     (d_st),
        .mem_vis_signal         (m_sig),
        .mem_vis_addr           (m_addr),
        .mem_written_data       (m_data),
        .mem_data_type          (m_type),
        .mem_write_length       (m_len),
        .mem_status             (m_status),
        .arb_timeout            (tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether a turnaround cycle is pending,
    // who was served last, how long the current owner has held the port.
    logic [1:0] mo_owner;
    bit         mo_cool;
    bit         mo_last_d;
    bit         mo_tmo;
    int         mo_age;

    logic [1:0]    e_sig;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [2:0]    e_type;
    logic [LW-1:0] e_len;
    logic [1:0]    e_ist;
    logic [1:0]    e_dst;

    function automatic bit i_wants();
        return i_sig == 2'b01;
    endfunction

    function automatic bit d_wants();
        return (d_sig == 2'b01) || (d_sig == 2'b10);
    endfunction

    function automatic void model_reset();
        mo_owner  = OWN_NONE;
        mo_cool   = 1'b0;
        mo_last_d = 1'b0;
        mo_tmo    = 1'b0;
        mo_age    = 0;
    endfunction

    function automatic void model_eval();
        e_sig  = '0;
        e_addr = '0;
        e_data = '0;
        e_type = '0;
        e_len  = '0;
        e_ist  = i_wants() ? M_BUSY : M_IDLE;
        e_dst  = d_wants() ? M_BUSY : M_IDLE;
        if (mo_owner == OWN_I) begin
            e_sig  = i_wants() ? 2'b01 : 2'b00;
            e_addr = i_addr;
            e_ist  = m_status;
        end else if (mo_owner == OWN_D) begin
            e_sig  = d_wants() ? d_sig : 2'b00;
            e_addr = d_addr;
            e_data = d_data;
            e_type = d_type;
            e_len  = d_len;
            e_dst  = m_status;
        end
    endfunction

    function automatic void model_advance();
        bit still;
        if (mo_owner != OWN_NONE) begin
            mo_age++;
            if (mo_age >= 255) mo_tmo = 1'b1;
            still = (mo_owner == OWN_I) ? i_wants() : d_wants();
            if (m_status == M_DONE) begin
                mo_last_d = (mo_owner == OWN_D);
                mo_owner  = OWN_NONE;
                mo_cool   = 1'b1;
            end else if (!still) begin
                mo_owner = OWN_NONE;
            end
        end else if (mo_cool) begin
            mo_cool = 1'b0;
        end else begin
            if (i_wants() && d_wants()) mo_owner = mo_last_d ? OWN_I : OWN_D;
            else if (i_wants())         mo_owner = OWN_I;
            else if (d_wants())         mo_owner = OWN_D;
            mo_age = 0;
        end
    endfunction

    task automatic compare_all();
        check("mem_vis_signal", m_sig, e_sig);
        check("mem_vis_addr", m_addr, e_addr);
        check("mem_written_data", m_data, e_data);
        check("mem_data_type", m_type, e_type);
        check("mem_write_length", m_len, e_len);
        check("i_cache_status", i_st, e_ist);
        check("d_cache_status", d_st, e_dst);
        check("arb_timeout", tmo, mo_tmo);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        i_sig    = '0;
        d_sig    = '0;
        m_status = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    int glog[$];

    // Caches re-request until their quota is used; memory answers after a few cycles.
    task automatic run_traffic(input int max_cyc, input int n_i, input int n_d,
                               input bit rnd, input bit log_en);
        int         i_left;
        int         d_left;
        bit         i_pend;
        bit         d_pend;
        logic [1:0] d_hold;
        bit         m_serv;
        int         m_rem;
        logic [1:0] prev_sig;
        int         cyc;
        i_left = n_i;  d_left = n_d;
        i_pend = 1'b0; d_pend = 1'b0;
        d_hold = 2'b01;
        m_serv = 1'b0; m_rem = 0;
        prev_sig = 2'b00;
        cyc = 0;
        while ((i_left > 0 || d_left > 0 || i_pend || d_pend) && cyc < max_cyc) begin
            if (!i_pend && i_left > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                i_pend = 1'b1;
                i_left--;
                i_addr = rnd ? 17'($urandom) : 17'h00020;
            end
            if (i_pend) i_sig = 2'b01;
            else begin
                i_sig = (rnd && $urandom_range(0, 3) == 0) ? 2'b10 :
                        (rnd && $urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
                if (rnd) i_addr = 17'($urandom);
            end
            if (!d_pend && d_left > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                d_pend = 1'b1;
                d_left--;
                d_hold = (rnd && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                d_addr = rnd ? 17'($urandom) : 17'h00030;
                d_data = rnd ? $urandom : 32'h0;
                d_type = rnd ? 3'($urandom_range(0, 7)) : 3'd0;
                d_len  = rnd ? 4'($urandom_range(0, 15)) : 4'd0;
            end
            d_sig = d_pend ? d_hold : ((rnd && $urandom_range(0, 4) == 0) ? 2'b11 : 2'b00);
            model_eval();
            if (!m_serv && e_sig != 2'b00) begin
                m_serv = 1'b1;
                m_rem  = rnd ? $urandom_range(1, 4) : 2;
            end
            m_status = m_serv ? ((m_rem == 1) ? M_DONE : M_BUSY)
                              : (rnd ? 2'($urandom_range(0, 1)) : M_IDLE);
            model_eval();
            @(negedge clk);
            compare_all();
            if (log_en && m_sig !== 2'b00 && prev_sig === 2'b00) begin
                glog.push_back((m_addr == 17'h00030) ? 2 : 1);
            end
            prev_sig = m_sig;
            if (e_ist == M_DONE) i_pend = 1'b0;
            if (e_dst == M_DONE) d_pend = 1'b0;
            if (m_serv) begin
                m_rem--;
                if (m_rem == 0) m_serv = 1'b0;
            end
            model_advance();
            @(posedge clk);
            #1;
            cyc++;
        end
        check("traffic_complete", i_left + d_left + int'(i_pend) + int'(d_pend), 0);
        i_sig = '0;
        d_sig = '0;
        m_status = '0;
    endtask

    typedef struct {
        logic       rst_v;
        logic [1:0] i_sig;
        logic [1:0] d_sig;
        logic [1:0] ms;
        logic [1:0] x_own;
        logic [1:0] x_sig;
        logic [1:0] x_ist;
        logic [1:0] x_dst;
    } vec_t;

    vec_t vecs [19];

    initial begin
        vecs = '{
            // ignored I code 10 / 11 and D code 11: no grant
            '{1'b1, 2'b10, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            '{1'b1, 2'b10, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            '{1'b1, 2'b11, 2'b11, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            // lone I read, memory DONE on the fourth grant-side cycle
            '{1'b1, 2'b01, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_BUSY, OWN_I,    2'b01, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_BUSY, OWN_I,    2'b01, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_BUSY, OWN_I,    2'b01, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_DONE, OWN_I,    2'b01, M_DONE, M_IDLE},
            '{1'b1, 2'b00, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            '{1'b1, 2'b00, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            // reset with both requesting, then a tie that goes to D
            '{1'b0, 2'b01, 2'b10, M_BUSY, OWN_NONE, 2'b00, M_IDLE, M_IDLE},
            '{1'b1, 2'b01, 2'b10, M_IDLE, OWN_NONE, 2'b00, M_BUSY, M_BUSY},
            '{1'b1, 2'b01, 2'b10, M_BUSY, OWN_D,    2'b10, M_BUSY, M_BUSY},
            '{1'b1, 2'b01, 2'b10, M_DONE, OWN_D,    2'b10, M_BUSY, M_DONE},
            '{1'b1, 2'b01, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_BUSY, OWN_I,    2'b01, M_BUSY, M_IDLE},
            '{1'b1, 2'b01, 2'b00, M_DONE, OWN_I,    2'b01, M_DONE, M_IDLE},
            '{1'b1, 2'b00, 2'b00, M_IDLE, OWN_NONE, 2'b00, M_IDLE, M_IDLE}
        };

        do_reset();
        check("reset_mem_sig", m_sig, 2'b00);
        check("reset_tmo", tmo, 1'b0);

        // Directed vector table
        i_addr = T_IADDR;
        d_addr = T_DADDR;
        d_data = T_DDATA;
        d_type = 3'd2;
        d_len  = 4'd4;
        foreach (vecs[n]) begin
            rst      = vecs[n].rst_v;
            i_sig    = vecs[n].i_sig;
            d_sig    = vecs[n].d_sig;
            m_status = vecs[n].ms;
            @(negedge clk);
            check($sformatf("v%0d_sig", n), m_sig, vecs[n].x_sig);
            check($sformatf("v%0d_addr", n), m_addr,
                  (vecs[n].x_own == OWN_I) ? T_IADDR : (vecs[n].x_own == OWN_D) ? T_DADDR : 17'h0);
            check($sformatf("v%0d_data", n), m_data, (vecs[n].x_own == OWN_D) ? T_DDATA : 32'h0);
            check($sformatf("v%0d_type", n), m_type, (vecs[n].x_own == OWN_D) ? 3'd2 : 3'd0);
            check($sformatf("v%0d_len", n), m_len, (vecs[n].x_own == OWN_D) ? 4'd4 : 4'd0);
            check($sformatf("v%0d_ist", n), i_st, vecs[n].x_ist);
            check($sformatf("v%0d_dst", n), d_st, vecs[n].x_dst);
            check($sformatf("v%0d_tmo", n), tmo, 1'b0);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        // Both caches keep re-requesting: turns must alternate D,I,D,I,D,I
        do_reset();
        glog.delete();
        run_traffic(200, 3, 3, 1'b0, 1'b1);
        check("alt_grant_count", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) begin
            check($sformatf("alt_grant_%0d", k), glog[k], (k % 2 == 0) ? 2 : 1);
        end

        // Asynchronous reset in the middle of a D grant
        do_reset();
        i_sig = 2'b01; i_addr = 17'h00040;
        d_sig = 2'b10; d_addr = 17'h00050; d_data = 32'h12345678; d_type = 3'd3; d_len = 4'd5;
        @(negedge clk);
        check("ar_idle_sig", m_sig, 2'b00);
        check("ar_idle_dst", d_st, M_BUSY);
        @(posedge clk);
        #1;
        m_status = M_BUSY;
        @(negedge clk);
        check("ar_grant_d_sig", m_sig, 2'b10);
        check("ar_grant_d_addr", m_addr, 17'h00050);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("ar_sig", m_sig, 2'b00);
        check("ar_addr", m_addr, 17'h0);
        check("ar_data", m_data, 32'h0);
        check("ar_type", m_type, 3'd0);
        check("ar_len", m_len, 4'd0);
        check("ar_ist", i_st, M_IDLE);
        check("ar_dst", d_st, M_IDLE);
        check("ar_tmo", tmo, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_status = M_IDLE;
        @(negedge clk);
        check("ar_after_sig", m_sig, 2'b00);
        check("ar_after_ist", i_st, M_BUSY);
        check("ar_after_dst", d_st, M_BUSY);
        @(posedge clk);
        #1;
        m_status = M_BUSY;
        @(negedge clk);
        check("ar_tie_to_d", m_sig, 2'b10);
        check("ar_tie_ist", i_st, M_BUSY);

        // Grant stuck BUSY for 300 cycles: timeout flag rises and stays set
        do_reset();
        i_sig = 2'b01; i_addr = 17'h00077;
        m_status = M_BUSY;
        @(negedge clk);
        check("to_idle_sig", m_sig, 2'b00);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) check("to_grant_sig", m_sig, 2'b01);
            if (k != 255) check($sformatf("to_flag_c%0d", k), tmo, k > 255);
            @(posedge clk);
            #1;
        end
        m_status = M_DONE;
        @(negedge clk);
        check("to_done_ist", i_st, M_DONE);
        check("to_done_tmo", tmo, 1'b1);
        @(posedge clk);
        #1;
        i_sig = 2'b00;
        m_status = M_IDLE;
        repeat (3) begin
            @(negedge clk);
            check("to_sticky_tmo", tmo, 1'b1);
            check("to_after_sig", m_sig, 2'b00);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the model
        do_reset();
        run_traffic(8000, 150, 150, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
